// File: rtl/cpu_step_controller_pkg.sv
// Shared types for the board-build execution controller.
// State encoding matches the LED/seven-segment display mux.
package cpu_step_controller_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  function automatic logic bp_match(
    input logic        en,
    input logic [63:0] pc,
    input logic [63:0] addr
  );
    return en && (pc == addr);
  endfunction

endpackage

// File: rtl/cpu_step_controller_if.sv
// Board/core-facing bundle of the execution controller.
// master = board + core side, slave = controller.
interface cpu_step_controller_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              run_sw;
  logic              step_btn;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic              cpu_ce;
  logic [1:0]        state;
  logic              bp_hit;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output run_sw, step_btn, halt_req,
    output pc, bp_en, bp_addr,
    input  cpu_ce, state, bp_hit, instr_count
  );

  modport slave (
    input  run_sw, step_btn, halt_req,
    input  pc, bp_en, bp_addr,
    output cpu_ce, state, bp_hit, instr_count
  );
endinterface

// File: rtl/cpu_step_controller_debounce_sync.sv
// 2-FF synchronizer followed by a stable-count debouncer.
// Level flips after DEB_CYCLES consecutive differing samples.
module debounce_sync #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff  = r_sync2 != r_level;
  assign w_done  = r_cnt == CW'(DEB_CYCLES - 1);
  assign o_level = r_level;
  assign o_rise  = r_rise;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/cpu_step_controller.sv
// Generates the core clock-enable: divided free-run, single-step,
// PC breakpoint pause and sticky halt on ECALL/EBREAK.
module cpu_step_controller
  import cpu_step_controller_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int RUN_DIV    = 25000000,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                 fastclk,
  input  logic                 rst,
  cpu_step_controller_if.slave bus
);
  localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

  state_e           r_state;
  logic             r_cpu_ce;
  logic             r_bp_hit;
  logic             r_bp_skip;
  logic [CNT_W-1:0] r_count;
  logic [DIV_W-1:0] r_div;

  logic w_run_db;
  logic w_run_rise;
  logic w_step_db;
  logic w_step_rise;
  logic w_div_tc;
  logic w_bp;

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_run_db (
    .i_clk   (fastclk),
    .i_rst   (rst),
    .i_raw   (bus.run_sw),
    .o_level (w_run_db),
    .o_rise  (w_run_rise)
  );

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_step_db (
    .i_clk   (fastclk),
    .i_rst   (rst),
    .i_raw   (bus.step_btn),
    .o_level (w_step_db),
    .o_rise  (w_step_rise)
  );

  assign w_div_tc = r_div == DIV_W'(RUN_DIV - 1);
  assign w_bp     = bp_match(bus.bp_en, 64'(bus.pc), 64'(bus.bp_addr));

  assign bus.cpu_ce      = r_cpu_ce;
  assign bus.state       = r_state;
  assign bus.bp_hit      = r_bp_hit;
  assign bus.instr_count = r_count;

  always_ff @(posedge fastclk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_PAUSE;
      r_cpu_ce  <= 1'b0;
      r_bp_hit  <= 1'b0;
      r_bp_skip <= 1'b0;
      r_count   <= '0;
      r_div     <= '0;
    end else begin
      r_cpu_ce <= 1'b0;
      unique case (r_state)
        ST_PAUSE: begin
          if (w_run_db) begin
            r_state   <= ST_RUN;
            r_div     <= '0;
            r_bp_skip <= 1'b1;
            r_bp_hit  <= 1'b0;
          end else if (w_step_rise) begin
            r_bp_hit <= 1'b0;
            if (bus.halt_req) begin
              r_state <= ST_HALT;
            end else begin
              r_state  <= ST_STEP;
              r_cpu_ce <= 1'b1;
              r_count  <= r_count + CNT_W'(1);
            end
          end
        end
        ST_STEP: begin
          r_state <= ST_PAUSE;
        end
        ST_RUN: begin
          // Leaving RUN takes priority over a terminal divider.
          if (!w_run_db) begin
            r_state <= ST_PAUSE;
          end else if (!w_div_tc) begin
            r_div <= r_div + DIV_W'(1);
          end else if (bus.halt_req) begin
            r_state <= ST_HALT;
          end else if (w_bp && !r_bp_skip) begin
            r_state  <= ST_PAUSE;
            r_bp_hit <= 1'b1;
          end else begin
            r_cpu_ce  <= 1'b1;
            r_count   <= r_count + CNT_W'(1);
            r_div     <= '0;
            r_bp_skip <= 1'b0;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_PAUSE;
        end
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_run_rise ^ w_step_db;
endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for the execution controller (DEB_CYCLES=4, RUN_DIV=3).
module tb_cpu_step_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   ce_cnt = 0;
  int   last_ce = -1;

  cpu_step_controller_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  cpu_step_controller #(
    .DEB_CYCLES(4),
    .RUN_DIV   (3),
    .ADDR_W    (32),
    .CNT_W     (16)
  ) dut (
    .fastclk (clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.cpu_ce) begin
      ce_cnt++;
      last_ce = cyc;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.run_sw = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    bus.pc = 32'h0;
    bus.bp_en = 1'b0;
    bus.bp_addr = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    ce_cnt = 0;
    last_ce = -1;
  endtask

  initial begin
    reset_dut();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_ce", int'(bus.cpu_ce), 0);
    chk("rst_bp_hit", int'(bus.bp_hit), 0);
    chk("rst_count", int'(bus.instr_count), 0);

    // single step from a held button
    bus.step_btn = 1'b1;
    repeat (7) tick();
    chk("step_ce", int'(bus.cpu_ce), 1);
    chk("step_state", int'(bus.state), 2);
    repeat (3) tick();
    bus.step_btn = 1'b0;
    repeat (10) tick();
    chk("step_pulses", ce_cnt, 1);
    chk("step_count", int'(bus.instr_count), 1);
    chk("step_back", int'(bus.state), 0);

    // short glitch is filtered
    bus.step_btn = 1'b1;
    repeat (2) tick();
    bus.step_btn = 1'b0;
    repeat (12) tick();
    chk("glitch_pulses", ce_cnt, 1);
    chk("glitch_state", int'(bus.state), 0);

    // free run
    reset_dut();
    bus.run_sw = 1'b1;
    repeat (10) tick();
    chk("run_first", last_ce, 10);
    chk("run_first_n", ce_cnt, 1);
    repeat (20) tick();
    chk("run_pulses", ce_cnt, 7);
    chk("run_last", last_ce, 28);
    chk("run_count", int'(bus.instr_count), 7);
    chk("run_state", int'(bus.state), 1);
    bus.run_sw = 1'b0;
    repeat (30) tick();
    chk("stop_pulses", ce_cnt, 9);
    chk("stop_last", last_ce, 34);
    chk("stop_state", int'(bus.state), 0);
    chk("stop_count", int'(bus.instr_count), 9);

    // breakpoint
    reset_dut();
    bus.bp_en = 1'b1;
    bus.bp_addr = 32'h10;
    bus.pc = 32'h10;
    bus.run_sw = 1'b1;
    repeat (10) tick();
    chk("bp_entry_ce", int'(bus.cpu_ce), 1);
    bus.pc = 32'h14;
    repeat (3) tick();
    chk("bp_other_ce", int'(bus.cpu_ce), 1);
    bus.pc = 32'h10;
    repeat (3) tick();
    chk("bp_hit_ce", int'(bus.cpu_ce), 0);
    chk("bp_hit_state", int'(bus.state), 0);
    chk("bp_hit_flag", int'(bus.bp_hit), 1);
    tick();
    chk("bp_resume_st", int'(bus.state), 1);
    chk("bp_resume_hit", int'(bus.bp_hit), 0);
    repeat (3) tick();
    chk("bp_skip_ce", int'(bus.cpu_ce), 1);
    chk("bp_count", int'(bus.instr_count), 3);
    bus.run_sw = 1'b0;
    bus.bp_en = 1'b0;
    repeat (20) tick();
    chk("bp_stop_state", int'(bus.state), 0);

    // halt at a divider terminal
    reset_dut();
    bus.run_sw = 1'b1;
    repeat (10) tick();
    chk("halt_pre_ce", int'(bus.cpu_ce), 1);
    repeat (2) tick();
    bus.halt_req = 1'b1;
    tick();
    chk("halt_ce", int'(bus.cpu_ce), 0);
    chk("halt_state", int'(bus.state), 3);
    chk("halt_count", int'(bus.instr_count), 1);
    bus.halt_req = 1'b0;
    bus.run_sw = 1'b0;
    repeat (10) tick();
    bus.step_btn = 1'b1;
    repeat (10) tick();
    bus.step_btn = 1'b0;
    bus.run_sw = 1'b1;
    repeat (10) tick();
    chk("halt_sticky_n", ce_cnt, 1);
    chk("halt_sticky_st", int'(bus.state), 3);
    reset_dut();
    chk("halt_rst_st", int'(bus.state), 0);
    chk("halt_rst_cnt", int'(bus.instr_count), 0);

    // step while halt_req is decoded
    bus.halt_req = 1'b1;
    bus.step_btn = 1'b1;
    repeat (7) tick();
    chk("step_halt_st", int'(bus.state), 3);
    chk("step_halt_n", ce_cnt, 0);

    // asynchronous reset during a pulse
    reset_dut();
    bus.step_btn = 1'b1;
    repeat (7) tick();
    chk("arst_pre_ce", int'(bus.cpu_ce), 1);
    rst = 1'b1;
    #1;
    chk("arst_ce", int'(bus.cpu_ce), 0);
    chk("arst_state", int'(bus.state), 0);
    chk("arst_count", int'(bus.instr_count), 0);
    chk("arst_bp_hit", int'(bus.bp_hit), 0);
    reset_dut();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Execution controller for the single-cycle RISC-V core on the board build.
- Runs in the fastclk domain; emits a one-cycle clock-enable (cpu_ce) that replaces the slowclk drive of the core.
- Supports free-run at a divided rate, single-step from a push button, PC breakpoint pause, and a sticky halt on ECALL/EBREAK.
- Exports state, a breakpoint-hit flag and a retired-instruction count for the LED/seven-segment display mux.

Parameters:
- DEB_CYCLES, 250000, number of consecutive stable samples a synchronized input needs before its debounced value changes.
- RUN_DIV, 25000000, fastclk cycles per cpu_ce pulse in RUN (minimum 2).
- ADDR_W, 32, width of pc and bp_addr.
- CNT_W, 16, width of instr_count.

Ports:
- fastclk  in  1  board clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- run_sw  in  1  raw run switch; 1 = run.
- step_btn  in  1  raw step push button; active high.
- halt_req  in  1  core decodes ECALL/EBREAK at the current PC (combinational from the core).
- pc  in  ADDR_W  current core PC.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint address.
- cpu_ce  out  1  registered one-cycle execute enable to the core.
- state  out  2  00 PAUSE, 01 RUN, 10 STEP, 11 HALT.
- bp_hit  out  1  set when a breakpoint caused a pause.
- instr_count  out  CNT_W  number of cpu_ce pulses issued.

Behaviour:
- Reset values: state=PAUSE, cpu_ce=0, bp_hit=0, instr_count=0, divider=0, bp_skip=0, and both debouncers report 0.
- Input conditioning:
  - run_sw and step_btn each pass through a 2-FF synchronizer, then a debounce counter.
  - The debounced value updates only after DEB_CYCLES consecutive samples that differ from the current debounced value.
  - step_rise is a one-cycle pulse on a 0->1 transition of the debounced step input.
- Issue check, applied at every potential cpu_ce:
  - halt_req=1 -> go to HALT; no cpu_ce.
  - Otherwise, if bp_en=1, pc==bp_addr and bp_skip=0 -> go to PAUSE, set bp_hit=1; no cpu_ce.
  - Otherwise the pulse issues.
- PAUSE:
  - run_db=1 -> RUN; divider cleared; bp_skip=1; bp_hit cleared.
  - Otherwise step_rise -> STEP if halt_req=0, or -> HALT if halt_req=1; bp_hit cleared.
  - If run_db=1 and step_rise occur in the same cycle, RUN wins.
- STEP:
  - cpu_ce=1 for exactly one cycle.
  - Returns to PAUSE on the next cycle.
  - Breakpoints are ignored in STEP.
- RUN:
  - run_db=0 -> PAUSE next cycle; no cpu_ce issued in that cycle, even if the divider is terminal.
  - Otherwise the divider counts 0..RUN_DIV-1. At RUN_DIV-1 the issue check runs; if it passes, cpu_ce=1 in the following cycle, the divider wraps to 0, and bp_skip clears.
  - First pulse after entering RUN comes RUN_DIV cycles after entry.
- HALT:
  - Sticky; cpu_ce stays 0; run_sw and step_btn are ignored.
  - Exit only via rst.
- cpu_ce:
  - Registered and never high in two consecutive cycles.
  - instr_count increments by 1 in the same cycle cpu_ce=1, modulo 2^CNT_W (wraps).
- Reset mid-operation:
  - rst asynchronously forces all reset values, including an in-flight cpu_ce.
  - Debounce counters restart, so a held button does not produce a step_rise until it is seen stable high for DEB_CYCLES after reset.

Decomposition:
- Shared package holds the state encoding constants (PAUSE, RUN, STEP, HALT).
- One sub-module, debounce_sync: 2-FF synchronizer plus stable-count debouncer, parameter DEB_CYCLES; outputs the level and a rise pulse. It is instantiated twice.

Test Plan:
Benches use DEB_CYCLES=4 and RUN_DIV=3.
- Reset, then step_btn held high for 10 cycles with halt_req=0 -> exactly one cpu_ce pulse, instr_count=1, state returns to 00.
- step_btn glitch high for 2 cycles -> no cpu_ce, state stays 00.
- run_sw held high for 30 cycles -> cpu_ce every 3rd cycle after run_db rises, instr_count increments by 1 per pulse, state=01; run_sw low -> state=00 and pulses stop.
- RUN with bp_en=1 and pc driven to bp_addr=0x00000010:
  - Entry pulse at 0x10 issues because bp_skip=1.
  - When pc next equals 0x10 -> no cpu_ce, state=00, bp_hit=1.
  - Toggling run back on resumes and clears bp_hit.
- RUN, then halt_req=1 at a divider terminal -> no pulse, state=11; later run_sw/step_btn activity gives no cpu_ce; rst -> state=00, instr_count=0.
- rst asserted in the same cycle cpu_ce=1 -> cpu_ce=0 immediately (asynchronous), all outputs at reset values.
